// File: rtl/eth_rx_stream_pkg.sv
// Shared types and helpers for the receive-buffer streamer.
// No logic of its own: FSM state encoding and the last-beat byte-enable helper.
// Backpressure: not applicable.
package eth_rx_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_ACK  = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    // Byte enables for the final beat of a frame. rem is the frame length
    // modulo the word size in bytes; zero means the last word is fully used.
    // Returned 8 bits wide to cover 64-bit words; callers truncate.
    function automatic logic [7:0] tkeep_from_rem(input int unsigned rem,
                                                  input int unsigned nbytes);
        logic [7:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            keep[i] = (rem == 0) ? (i < nbytes) : (i < rem);
        end
        return keep;
    endfunction

endpackage

// File: rtl/eth_rx_skid_buf.sv
// Two-entry FIFO holding stream beats (data + tkeep + tlast) between buffer reads and AXIS.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: head holds until pop_rdy_i; the producer must never push into a full buffer
// unless the same cycle pops (the streamer's credit count guarantees this).
// Ports: clk_i/reset_n_i, push_vld_i/push_dat_i (write side), pop_vld_o/pop_rdy_i/pop_dat_o (head).
module eth_rx_skid_buf #(
    parameter int width_p = 37
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_vld_i,
    input  logic [width_p-1:0] push_dat_i,
    output logic               pop_vld_o,
    input  logic               pop_rdy_i,
    output logic [width_p-1:0] pop_dat_o
);

    logic [width_p-1:0] mem_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         cnt_q;
    logic               do_push;
    logic               do_pop;

    assign pop_vld_o = (cnt_q != 2'd0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_pop    = pop_vld_o && pop_rdy_i;
    assign do_push   = push_vld_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            // With one entry held, the write pointer targets the other slot,
            // so the head never changes while it waits for a handshake.
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/eth_rx_packet_streamer.sv
// Reads frames out of the receiver packet buffer and re-emits them as an AXI-Stream master.
// Latency: first tvalid 2 cycles after leaving IDLE, then one beat per cycle while tready is high.
// Backpressure: at most 2 reads in flight or buffered; reads stall when the skid buffer has no credit.
// Ports: packet_* = receiver buffer read port (avail/rsize in, ack/rvalid/raddr out, rdata in),
// m_axis_* = stream output, busy_o/pkt_count_o/drop_count_o = status.
module eth_rx_packet_streamer
    import eth_rx_stream_pkg::*;
#(
    parameter  int eth_mtu_p            = 2048,
    parameter  int data_width_p         = 32,
    localparam int addr_width_lp        = $clog2(eth_mtu_p),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1),
    localparam int bytes_lp             = data_width_p / 8
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            packet_avail_i,
    input  logic [packet_size_width_lp-1:0] packet_rsize_i,
    output logic                            packet_ack_o,
    output logic                            packet_rvalid_o,
    output logic [addr_width_lp-1:0]        packet_raddr_o,
    input  logic [data_width_p-1:0]         packet_rdata_i,
    output logic [data_width_p-1:0]         m_axis_tdata_o,
    output logic [bytes_lp-1:0]             m_axis_tkeep_o,
    output logic                            m_axis_tvalid_o,
    output logic                            m_axis_tlast_o,
    input  logic                            m_axis_tready_i,
    output logic                            busy_o,
    output logic [15:0]                     pkt_count_o,
    output logic [15:0]                     drop_count_o
);

    localparam int shift_lp  = $clog2(bytes_lp);
    localparam int psw_lp    = packet_size_width_lp;
    localparam int skid_w_lp = data_width_p + bytes_lp + 1;

    state_e                   state_q;
    logic [psw_lp-1:0]        nbeats_q;
    logic [psw_lp-1:0]        issued_q;
    logic [psw_lp-1:0]        popped_q;
    logic [shift_lp-1:0]      rem_q;
    logic [addr_width_lp-1:0] raddr_q;
    logic                     rd_pend_q;
    logic                     rd_last_q;
    logic                     ack_q;
    logic [15:0]              pkt_cnt_q;
    logic [15:0]              drop_cnt_q;

    logic                     rd_fire;
    logic                     rd_is_last;
    logic                     pop;
    logic [psw_lp-1:0]        inflight;
    logic [psw_lp:0]          rsize_round;
    logic [psw_lp-1:0]        nbeats_calc;
    logic [bytes_lp-1:0]      keep_last;
    logic [skid_w_lp-1:0]     skid_in;
    logic [skid_w_lp-1:0]     skid_out;

    assign rsize_round = {1'b0, packet_rsize_i} + (psw_lp + 1)'(bytes_lp - 1);
    assign nbeats_calc = psw_lp'(rsize_round >> shift_lp);

    assign pop = m_axis_tvalid_o && m_axis_tready_i;

    // Credits: reads issued but not yet consumed, counting a pop happening
    // this cycle as already free so the pipeline sustains one beat per cycle.
    assign inflight   = issued_q - popped_q - psw_lp'(pop);
    assign rd_fire    = (state_q == ST_READ) && (issued_q < nbeats_q) &&
                        (inflight < psw_lp'(2));
    assign rd_is_last = (issued_q == nbeats_q - psw_lp'(1));

    assign keep_last = bytes_lp'(tkeep_from_rem(32'(rem_q), bytes_lp));
    assign skid_in   = {rd_last_q, (rd_last_q ? keep_last : {bytes_lp{1'b1}}), packet_rdata_i};

    eth_rx_skid_buf #(
        .width_p (skid_w_lp)
    ) u_skid (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .push_vld_i (rd_pend_q),
        .push_dat_i (skid_in),
        .pop_vld_o  (m_axis_tvalid_o),
        .pop_rdy_i  (m_axis_tready_i),
        .pop_dat_o  (skid_out)
    );

    assign m_axis_tdata_o  = skid_out[data_width_p-1:0];
    assign m_axis_tkeep_o  = skid_out[data_width_p +: bytes_lp];
    assign m_axis_tlast_o  = skid_out[skid_w_lp-1];

    assign packet_rvalid_o = rd_fire;
    assign packet_raddr_o  = raddr_q;
    assign packet_ack_o    = ack_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign pkt_count_o     = pkt_cnt_q;
    assign drop_count_o    = drop_cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            nbeats_q   <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            rem_q      <= '0;
            raddr_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            ack_q      <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            ack_q     <= 1'b0;
            // Read data returns one cycle after the strobe; tag it for the skid push.
            rd_pend_q <= rd_fire;
            rd_last_q <= rd_fire && rd_is_last;

            unique case (state_q)
                ST_IDLE: begin
                    if (packet_avail_i) begin
                        if (packet_rsize_i == '0) begin
                            state_q    <= ST_ACK;
                            ack_q      <= 1'b1;
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end else begin
                            state_q  <= ST_READ;
                            nbeats_q <= nbeats_calc;
                            rem_q    <= packet_rsize_i[shift_lp-1:0];
                            issued_q <= '0;
                            popped_q <= '0;
                            raddr_q  <= '0;
                        end
                    end
                end
                ST_READ: begin
                    // packet_avail_i is deliberately ignored here: a frame in
                    // progress is always finished.
                    if (rd_fire) begin
                        issued_q <= issued_q + psw_lp'(1);
                        // Stop stepping on the final read so the address stays
                        // inside the frame.
                        if (!rd_is_last) begin
                            raddr_q <= raddr_q + addr_width_lp'(bytes_lp);
                        end
                    end
                    if (pop) begin
                        popped_q <= popped_q + psw_lp'(1);
                        if (m_axis_tlast_o) begin
                            state_q   <= ST_ACK;
                            ack_q     <= 1'b1;
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        end
                    end
                end
                ST_ACK: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_packet_streamer.sv
module tb_eth_rx_packet_streamer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        packet_avail;
    logic [11:0] packet_rsize;
    logic        packet_ack;
    logic        packet_rvalid;
    logic [10:0] packet_raddr;
    logic [31:0] packet_rdata;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    eth_rx_packet_streamer dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .packet_avail_i  (packet_avail),
        .packet_rsize_i  (packet_rsize),
        .packet_ack_o    (packet_ack),
        .packet_rvalid_o (packet_rvalid),
        .packet_raddr_o  (packet_raddr),
        .packet_rdata_i  (packet_rdata),
        .m_axis_tdata_o  (tdata),
        .m_axis_tkeep_o  (tkeep),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tlast_o  (tlast),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .pkt_count_o     (pkt_count),
        .drop_count_o    (drop_count)
    );

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    tready_mode = 0;
    logic [7:0] mem [0:2047];
    beat_t exp_q [$];

    // per-frame bookkeeping, written by the monitor
    int    exp_addr = 0;
    int    strobes = 0;
    int    pops = 0;
    int    first_tv_cyc = -1;
    int    first_strobe_cyc = -1;
    int    last_cyc = -1;
    int    ack_cnt = 0;
    int    last_ack_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Sink ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                1: tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2: tready = ($urandom_range(0, 2) != 0);
                default: tready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, AXIS hold rule, read strobes and buffer model.
    initial begin
        logic        prev_stall;
        logic [36:0] prev_bus;
        logic        prev_ack;
        logic        rd_pend;
        int          rd_addr;
        beat_t       e;
        prev_stall = 1'b0;
        prev_bus   = '0;
        prev_ack   = 1'b0;
        rd_pend    = 1'b0;
        rd_addr    = 0;
        forever begin
            @(negedge clk);
            rd_pend = 1'b0;
            if (!reset_n) begin
                prev_stall = 1'b0;
                prev_ack   = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", tvalid, 1);
                    check("hold_bus", {tlast, tkeep, tdata}, prev_bus);
                end
                if (tvalid && first_tv_cyc < 0) first_tv_cyc = cyc;
                if (tvalid && tready) begin
                    pops++;
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tdata", tdata, e.data);
                        check("tkeep", tkeep, e.keep);
                        check("tlast", tlast, e.last);
                    end
                    if (tlast) last_cyc = cyc;
                end
                prev_stall = tvalid && !tready;
                prev_bus   = {tlast, tkeep, tdata};

                if (packet_rvalid) begin
                    check("raddr", packet_raddr, exp_addr);
                    exp_addr += 4;
                    strobes++;
                    if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                    check("outstanding_le2", (strobes - pops) <= 2, 1);
                    rd_pend = 1'b1;
                    rd_addr = int'(packet_raddr);
                end

                if (packet_ack) begin
                    check("ack_one_cycle", prev_ack, 0);
                    ack_cnt++;
                    last_ack_cyc = cyc;
                end
                prev_ack = packet_ack;
            end
            @(posedge clk);
            #1;
            if (rd_pend) packet_rdata = word(rd_addr);
        end
    end

    task automatic prep_frame(input int size, input logic [3:0] last_keep, input int seed);
        int    nb;
        beat_t e;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 5 + seed);
        nb = (size + 3) / 4;
        for (int j = 0; j < nb; j++) begin
            e.data = word(4 * j);
            e.keep = (j == nb - 1) ? last_keep : 4'hF;
            e.last = (j == nb - 1);
            exp_q.push_back(e);
        end
        exp_addr         = 0;
        strobes          = 0;
        pops             = 0;
        first_tv_cyc     = -1;
        first_strobe_cyc = -1;
        last_cyc         = -1;
    endtask

    task automatic wait_ack();
        int  k;
        logic seen;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 3000) begin
            @(negedge clk);
            #1;
            if (packet_ack) seen = 1'b1;
            k++;
        end
        check("ack_seen", seen, 1);
    endtask

    task automatic run_frame(input int size, input logic [3:0] last_keep, input int mode,
                             input logic hold_avail, input int seed, output int gap);
        int nb;
        int ack_before;
        nb = (size + 3) / 4;
        ack_before = last_ack_cyc;
        prep_frame(size, last_keep, seed);
        @(posedge clk);
        #1;
        tready_mode  = mode;
        packet_rsize = 12'(size);
        packet_avail = 1'b1;
        wait_ack();
        check("beats", pops, nb);
        if (mode == 0 && nb > 0) begin
            check("first_tvalid_latency", first_tv_cyc - first_strobe_cyc, 2);
            check("one_beat_per_cycle", last_cyc - first_tv_cyc, nb - 1);
        end
        if (nb == 0) check("no_tvalid", first_tv_cyc, -1);
        gap = first_strobe_cyc - ack_before;
        @(negedge clk);
        check("ack_dropped", packet_ack, 0);
        if (!hold_avail) begin
            @(posedge clk);
            #1;
            packet_avail = 1'b0;
        end
    endtask

    initial begin
        int gap;
        int k;
        int acks_before;
        reset_n      = 1'b0;
        packet_avail = 1'b0;
        packet_rsize = '0;
        packet_rdata = '0;
        #2;
        check("reset_outputs",
              {packet_ack, packet_rvalid, packet_raddr, tvalid, tlast, tkeep, tdata, busy},
              64'd0);
        check("reset_counters", {pkt_count, drop_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // full-word frame, sink always ready
        run_frame(64, 4'hF, 0, 1'b0, 1, gap);
        check("pkt_count_64", pkt_count, 1);
        check("drop_count_64", drop_count, 0);
        check("ack_count_64", ack_cnt, 1);
        check("idle_after", busy, 0);

        // partial last words
        run_frame(61, 4'h1, 0, 1'b0, 2, gap);
        run_frame(62, 4'h3, 0, 1'b0, 3, gap);
        run_frame(63, 4'h7, 0, 1'b0, 4, gap);
        check("pkt_count_partial", pkt_count, 4);

        // stalled sink
        run_frame(64, 4'hF, 1, 1'b0, 5, gap);
        run_frame(64, 4'hF, 2, 1'b0, 6, gap);
        check("pkt_count_stall", pkt_count, 6);

        // zero-length frame is dropped
        run_frame(0, 4'hF, 0, 1'b0, 7, gap);
        check("drop_count_zero", drop_count, 1);
        check("pkt_count_zero", pkt_count, 6);
        check("ack_count_zero", ack_cnt, 7);

        // back-to-back frames with avail held high
        run_frame(8, 4'hF, 0, 1'b1, 8, gap);
        run_frame(5, 4'h1, 0, 1'b0, 9, gap);
        check("b2b_gap", gap, 3);
        check("pkt_count_b2b", pkt_count, 8);

        // reset during beat 3 of a 64-byte frame
        prep_frame(64, 4'hF, 10);
        @(posedge clk);
        #1;
        tready_mode  = 0;
        packet_rsize = 12'd64;
        packet_avail = 1'b1;
        k = 0;
        while (pops < 3 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("reached_beat3", pops, 3);
        acks_before = ack_cnt;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {packet_ack, packet_rvalid, packet_raddr, tvalid, tlast, tkeep, tdata, busy},
              64'd0);
        check("async_reset_counters", {pkt_count, drop_count}, 32'd0);
        exp_q.delete();
        prep_frame(64, 4'hF, 10);
        repeat (3) @(posedge clk);
        check("no_ack_in_reset", ack_cnt, acks_before);
        #1;
        reset_n = 1'b1;
        wait_ack();
        check("reread_beats", pops, 16);
        check("reread_ack_count", ack_cnt, acks_before + 1);
        check("pkt_count_after_reset", pkt_count, 1);
        check("drop_count_after_reset", drop_count, 0);
        @(posedge clk);
        #1;
        packet_avail = 1'b0;
        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
